midi_uart_rx: RTL and testbench

//  Parametrised serial receiver; successor of the fixed 8N1 MIDI RX frontend.

---
 rtl/midi_uart_rx.sv | 101 ++++++++++
 tb/tb_midi_uart_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: parametrised serial receiver with 3-sample majority vote and valid/ready output
module midi_uart_rx #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BIT_RATE_HZ = 31250,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rxData_i,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parityErr_o,
  output logic                 frameErr_o,
  output logic                 overrun_o
);
  localparam int CPB  = CLK_HZ / BIT_RATE_HZ;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB) + 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t               r_state, w_next;
  logic                 r_sync, r_rxs, r_armed, r_s0, r_s1, r_par, r_ferr;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bitn;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_bit, w_dec, w_end, w_done, w_ferr, w_perr;
  assign w_bit  = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);
  assign w_dec  = (r_state != S_IDLE) && (r_cnt == CW'(HALF + 1));
  assign w_end  = r_cnt == CW'(CPB - 1);
  assign w_done = (r_state == S_STOP) && w_dec && (r_bitn == 4'(STOP_BITS - 1));
  assign w_ferr = r_ferr | ~w_bit;
  assign w_perr = (PARITY == 0) ? 1'b0 : ((^r_shift) ^ r_par ^ (PARITY == 1));
  // next-state: the last stop decision returns to IDLE at mid-bit to leave resync margin
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (!r_rxs && r_armed) ? S_START : S_IDLE;
      S_START: w_next = (w_dec && w_bit) ? S_IDLE : w_end ? S_DATA : S_START;
      S_DATA:  w_next = (w_end && r_bitn == 4'(DATA_BITS - 1)) ? ((PARITY != 0) ? S_PAR : S_STOP) : S_DATA;
      S_PAR:   w_next = w_end ? S_STOP : S_PAR;
      S_STOP:  w_next = w_done ? S_IDLE : S_STOP;
      default: w_next = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  // synchroniser, bit timing, sampling and frame assembly; armed only re-arms on a high line so a break cannot retrigger
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync  <= 1'b1;
      r_rxs   <= 1'b1;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_par   <= 1'b0;
      r_ferr  <= 1'b0;
      r_shift <= '0;
    end else begin
      r_sync  <= rxData_i;
      r_rxs   <= r_sync;
      r_armed <= (r_state == S_IDLE) ? r_rxs : r_armed;
      r_cnt   <= (r_state == S_IDLE || w_end) ? '0 : r_cnt + CW'(1);
      r_bitn  <= (w_next != r_state) ? '0 : (w_end && (r_state == S_DATA || r_state == S_STOP)) ? r_bitn + 4'd1 : r_bitn;
      r_ferr  <= (r_state == S_STOP) ? (r_ferr | (w_dec & ~w_bit)) : 1'b0;
      if (r_cnt == CW'(HALF - 1)) r_s0 <= r_rxs;
      if (r_cnt == CW'(HALF)) r_s1 <= r_rxs;
      if (r_state == S_DATA && w_dec) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
      if (r_state == S_PAR && w_dec) r_par <= w_bit;
    end
  end
  // output holding register: load on completion when free or being accepted, otherwise flag overrun
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      parityErr_o <= 1'b0;
      frameErr_o  <= 1'b0;
      overrun_o   <= 1'b0;
    end else if (w_done) begin
      if (!valid_o || ready_i) begin
        data_o      <= r_shift;
        parityErr_o <= w_perr;
        frameErr_o  <= w_ferr;
        valid_o     <= 1'b1;
        overrun_o   <= 1'b0;
      end else begin
        overrun_o   <= 1'b1;
      end
    end else if (valid_o && ready_i) begin
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_midi_uart_rx.sv
// tb_midi_uart_rx: scoreboard bench for 8N1, 8E1 and 9N2 receiver instances
module tb_midi_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = 8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] line = 3'b111;
  logic [2:0] ready = 3'b111;
  wire  [2:0] valid, perr, ferr, ovr;
  wire  [7:0] a_data, b_data;
  wire  [8:0] c_data;
  int         nb[3] = '{8, 8, 9};
  int         par[3] = '{0, 2, 0};
  int         ns[3] = '{1, 1, 2};
  int         n_vec = 0;
  int         n_err = 0;
  int         lat;
  logic [11:0] q0[$], q1[$], q2[$];
  always #5 clk = ~clk;
  midi_uart_rx #(.CLK_HZ(1_600_000), .BIT_RATE_HZ(100_000)) u_a (
    .clk_i(clk), .rst_i(rst), .rxData_i(line[0]), .ready_i(ready[0]), .data_o(a_data),
    .valid_o(valid[0]), .parityErr_o(perr[0]), .frameErr_o(ferr[0]), .overrun_o(ovr[0]));
  midi_uart_rx #(.CLK_HZ(1_600_000), .BIT_RATE_HZ(100_000), .PARITY(2)) u_b (
    .clk_i(clk), .rst_i(rst), .rxData_i(line[1]), .ready_i(ready[1]), .data_o(b_data),
    .valid_o(valid[1]), .parityErr_o(perr[1]), .frameErr_o(ferr[1]), .overrun_o(ovr[1]));
  midi_uart_rx #(.CLK_HZ(1_600_000), .BIT_RATE_HZ(100_000), .DATA_BITS(9), .STOP_BITS(2)) u_c (
    .clk_i(clk), .rst_i(rst), .rxData_i(line[2]), .ready_i(ready[2]), .data_o(c_data),
    .valid_o(valid[2]), .parityErr_o(perr[2]), .frameErr_o(ferr[2]), .overrun_o(ovr[2]));
  function automatic logic [8:0] dat(input int i);
    return (i == 0) ? {1'b0, a_data} : (i == 1) ? {1'b0, b_data} : c_data;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input int i, input logic [11:0] e);
    if (i == 0) q0.push_back(e);
    else if (i == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask
  task automatic check(input int i);
    logic [11:0] act, exp;
    int          sz;
    act = {ovr[i], ferr[i], perr[i], dat(i)};
    sz  = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
    n_vec++;
    if (sz == 0) begin
      n_err++;
      $display("FAIL word[%0d]: got unexpected %03h expected no word", i, act);
    end else begin
      exp = (i == 0) ? q0.pop_front() : (i == 1) ? q1.pop_front() : q2.pop_front();
      if (act != exp) begin
        n_err++;
        $display("FAIL word[%0d]: got %03h expected %03h", i, act, exp);
      end
    end
  endtask
  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < 3; i++)
        if (valid[i] && ready[i]) check(i);
  task automatic idle(input int bits);
    repeat (bits * CPB) @(posedge clk);
    #1;
  endtask
  task automatic send(input int i, input logic [8:0] d, input bit pflip, input logic [1:0] st,
                      input int gb, input bit hold_low, input bit do_push, input bit ov);
    logic [15:0] b;
    int          n, ones;
    bit          p, pe, fe;
    b = '1;
    b[0] = 1'b0;
    n = 1;
    ones = 0;
    for (int k = 0; k < nb[i]; k++) begin
      b[n] = d[k];
      ones += int'(d[k]);
      n++;
    end
    if (par[i] != 0) begin
      p = ((par[i] == 2) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ pflip;
      b[n] = p;
      ones += int'(p);
      n++;
    end
    pe = (par[i] == 0) ? 1'b0 : (par[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    fe = 1'b0;
    for (int k = 0; k < ns[i]; k++) begin
      b[n] = st[k];
      if (!st[k]) fe = 1'b1;
      n++;
    end
    if (do_push) push(i, {ov, fe, pe, d});
    for (int k = 0; k < n; k++) begin
      line[i] = b[k];
      if (k == gb) begin
        repeat (HALF + 1) @(posedge clk);
        #1 line[i] = ~b[k];
        @(posedge clk);
        #1 line[i] = b[k];
        repeat (CPB - HALF - 2) @(posedge clk);
      end else repeat (CPB) @(posedge clk);
      #1;
    end
    line[i] = hold_low ? 1'b0 : 1'b1;
  endtask
  initial begin
    int       i, gb;
    logic [8:0] d;
    logic [1:0] st;
    bit       pf;
    repeat (4) @(posedge clk);
    #1;
    chk("rst valid", int'(valid), 0);
    chk("rst flags", int'({perr, ferr, ovr}), 0);
    chk("rst data", int'(dat(0)) | int'(dat(2)), 0);
    rst = 1'b0;
    idle(2);
    fork
      send(0, 9'h090, 1'b0, 2'b11, -1, 1'b0, 1'b1, 1'b0);
      begin
        lat = 0;
        do begin
          @(posedge clk);
          #1 lat++;
        end while (!valid[0] && lat < 400);
      end
    join
    chk("latency window", int'(lat >= 155 && lat <= 157), 1);
    chk("valid one clk", int'(valid[0]), 0);
    idle(1);
    send(1, 9'h03C, 1'b0, 2'b11, -1, 1'b0, 1'b1, 1'b0);
    idle(1);
    send(1, 9'h03C, 1'b1, 2'b11, -1, 1'b0, 1'b1, 1'b0);
    idle(1);
    send(0, 9'h0C3, 1'b0, 2'b00, -1, 1'b1, 1'b1, 1'b0);
    idle(10);
    line[0] = 1'b1;
    idle(2);
    line[0] = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1 line[0] = 1'b1;
    idle(2);
    chk("false start no word", int'(valid[0]), 0);
    send(0, 9'h045, 1'b0, 2'b11, -1, 1'b0, 1'b1, 1'b0);
    idle(1);
    send(0, 9'h0B7, 1'b0, 2'b11, 4, 1'b0, 1'b1, 1'b0);
    idle(1);
    ready[0] = 1'b0;
    send(0, 9'h011, 1'b0, 2'b11, -1, 1'b0, 1'b1, 1'b1);
    send(0, 9'h022, 1'b0, 2'b11, -1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("held valid", int'(valid[0]), 1);
    chk("held data", int'(a_data), 'h11);
    chk("overrun set", int'(ovr[0]), 1);
    ready[0] = 1'b1;
    @(posedge clk);
    #1 ready[0] = 1'b0;
    chk("accept valid", int'(valid[0]), 0);
    chk("accept overrun", int'(ovr[0]), 0);
    send(0, 9'h05A, 1'b0, 2'b11, -1, 1'b0, 1'b1, 1'b0);
    idle(1);
    fork
      send(0, 9'h06B, 1'b0, 2'b11, -1, 1'b0, 1'b1, 1'b0);
      begin
        repeat (3 + 9 * CPB + HALF + 1) @(posedge clk);
        #1 ready[0] = 1'b1;
        @(posedge clk);
        #1 ready[0] = 1'b0;
      end
    join
    chk("same-cycle valid", int'(valid[0]), 1);
    chk("same-cycle data", int'(a_data), 'h6B);
    chk("same-cycle overrun", int'(ovr[0]), 0);
    ready[0] = 1'b1;
    idle(1);
    fork
      send(0, 9'h0AA, 1'b0, 2'b11, -1, 1'b0, 1'b0, 1'b0);
      begin
        repeat (4 * CPB + HALF) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid-frame rst valid", int'(valid[0]), 0);
        chk("mid-frame rst data", int'(a_data), 0);
        chk("mid-frame rst flags", int'({perr[0], ferr[0], ovr[0]}), 0);
        repeat (100) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    idle(2);
    send(0, 9'h055, 1'b0, 2'b11, -1, 1'b0, 1'b1, 1'b0);
    idle(1);
    send(2, 9'h1A5, 1'b0, 2'b11, -1, 1'b0, 1'b1, 1'b0);
    idle(1);
    send(2, 9'h1A5, 1'b0, 2'b01, -1, 1'b0, 1'b1, 1'b0);
    idle(1);
    for (int t = 0; t < 40; t++) begin
      i  = $urandom_range(0, 2);
      d  = 9'($urandom_range(0, (1 << nb[i]) - 1));
      pf = (i == 1) && ($urandom_range(0, 3) == 0);
      st = {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)};
      gb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb[i]) : -1;
      send(i, d, pf, st, gb, 1'b0, 1'b1, 1'b0);
      idle(1);
    end
    idle(2);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    chk("q2 drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
